atan2_clocked: RTL and testbench



---
 rtl/cordic_pkg.sv | 49 ++++
 rtl/cordic_vec_stage.sv | 37 +++
 rtl/atan2_clocked.sv | 147 ++++++++++++++
 tb/tb_atan2_clocked.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: 4Q22 arctangent table, quarter/half-turn angles
// and the state encoding of the iterative phase extractor.
package cordic_pkg;

  // Fractional bits of the stored angle constants (4Q22).
  localparam int TAB_P = 22;

  // pi and pi/2 in 4Q22, truncated toward zero like the table entries.
  localparam logic signed [25:0] PI_4Q22   = 26'sd13176794;
  localparam logic signed [25:0] PI_2_4Q22 = 26'sd6588397;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // atan(2^-k) in 4Q22, truncated; k = 0..21, zero beyond the table.
  function automatic logic signed [25:0] atan_4q22(input logic [4:0] k);
    logic signed [25:0] v;
    case (k)
      5'd0:  v = 26'sd3294198;
      5'd1:  v = 26'sd1944679;
      5'd2:  v = 26'sd1027514;
      5'd3:  v = 26'sd521582;
      5'd4:  v = 26'sd261803;
      5'd5:  v = 26'sd131029;
      5'd6:  v = 26'sd65530;
      5'd7:  v = 26'sd32767;
      5'd8:  v = 26'sd16383;
      5'd9:  v = 26'sd8191;
      5'd10: v = 26'sd4095;
      5'd11: v = 26'sd2047;
      5'd12: v = 26'sd1023;
      5'd13: v = 26'sd511;
      5'd14: v = 26'sd255;
      5'd15: v = 26'sd127;
      5'd16: v = 26'sd63;
      5'd17: v = 26'sd31;
      5'd18: v = 26'sd15;
      5'd19: v = 26'sd7;
      5'd20: v = 26'sd3;
      5'd21: v = 26'sd1;
      default: v = 26'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One CORDIC vectoring micro-rotation: drives y toward zero and accumulates
// the rotated angle in z. Purely combinational; the FSM iterates it.
module cordic_vec_stage #(
  parameter int W  = 29,
  parameter int ZW = 26,
  parameter int KW = 5
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [ZW-1:0] z,
  input  logic [KW-1:0]        k,
  input  logic signed [ZW-1:0] atan_k,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // Rotate by -/+ atan(2^-k) depending on the sign of y; both updates use
  // the pre-rotation x and y.
  always_comb begin
    x_sh = x >>> k;
    y_sh = y >>> k;
    if (!y[W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_k;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_k;
    end
  end

endmodule

// File: rtl/atan2_clocked.sv
// Iterative CORDIC vectoring phase extractor: atan2(y, x) of a 3Qp pair,
// returned as a pdQp angle in [-pi, +pi], one micro-rotation per clock.
//
// Handshake: i_start is looked at only in IDLE; an accepted start raises
// o_busy on the next cycle, o_busy stays high through the result cycle, and
// o_valid pulses for exactly that one cycle with o_phi, which then holds
// until the next o_valid. Starts while busy (including the o_valid cycle)
// are dropped without any indication.
module atan2_clocked
  import cordic_pkg::*;
#(
  parameter int pd   = 4,
  parameter int p    = 22,
  parameter int ITER = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [3+p-1:0]    i_x,
  input  logic [3+p-1:0]    i_y,
  output logic              o_busy,
  output logic              o_valid,
  output logic [pd+p-1:0]   o_phi,
  output state_t            o_dbg_state
);

  // 5 integer bits hold the CORDIC gain growth, 2 guard fractional bits.
  localparam int W  = 5 + p + 2;
  localparam int ZW = pd + p;
  localparam int KW = 5;
  localparam int SH = TAB_P - p;

  localparam logic signed [ZW-1:0] PI_2_P = ZW'(PI_2_4Q22 >>> SH);

  state_t              state;
  logic [KW-1:0]       k;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic signed [ZW-1:0] z_q;
  logic                zero_q;

  logic signed [W-1:0]  xs;
  logic signed [W-1:0]  ys;
  logic signed [W-1:0]  x0;
  logic signed [W-1:0]  y0;
  logic signed [ZW-1:0] z0;
  logic signed [ZW-1:0] atan_k;
  logic signed [W-1:0]  x_n;
  logic signed [W-1:0]  y_n;
  logic signed [ZW-1:0] z_n;

  // Quadrant pre-rotation of the sign-extended operands into the right half
  // plane; y = 0 with x < 0 lands on +pi/2, so that case resolves to +pi.
  always_comb begin
    xs = {{2{i_x[3+p-1]}}, i_x, 2'b00};
    ys = {{2{i_y[3+p-1]}}, i_y, 2'b00};
    if (!xs[W-1]) begin
      x0 = xs;
      y0 = ys;
      z0 = '0;
    end else if (!ys[W-1]) begin
      x0 = ys;
      y0 = -xs;
      z0 = PI_2_P;
    end else begin
      x0 = -ys;
      y0 = xs;
      z0 = -PI_2_P;
    end
  end

  // Table entry for the current micro-rotation, rescaled to p fraction bits.
  always_comb begin
    atan_k = ZW'(atan_4q22(k) >>> SH);
  end

  cordic_vec_stage #(
    .W  (W),
    .ZW (ZW),
    .KW (KW)
  ) u_stage (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .k      (k),
    .atan_k (atan_k),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  assign o_dbg_state = state;

  // Control FSM with registered handshake outputs and the rotation datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_phi   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            x_q    <= x0;
            y_q    <= y0;
            z_q    <= z0;
            // A zero vector has no angle; the iterations would still walk
            // z upward, so the result is forced to 0 instead.
            zero_q <= (i_x == '0) && (i_y == '0);
            k      <= '0;
            o_busy <= 1'b1;
            state  <= ST_ROT;
          end
        end
        ST_ROT: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          k   <= k + 1'b1;
          if (k == KW'(ITER - 1)) begin
            o_phi   <= zero_q ? '0 : z_n;
            o_valid <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_clocked.sv
// Bench for atan2_clocked: vector table, handshake corner cases, reset abort
// and a random-angle sweep against a real-valued atan2 reference.
module tb_atan2_clocked;
  import cordic_pkg::*;

  localparam int PD   = 4;
  localparam int P    = 22;
  localparam int ITER = 20;
  localparam int XW   = 3 + P;
  localparam int ZW   = PD + P;
  localparam longint ONE = 64'sd4194304;
  // Residual angle after ITER steps plus up to one LSB of truncation per
  // table entry used, plus rounding slack.
  localparam longint SWEEP_TOL = (64'sd1 << (P - ITER + 1)) + ITER + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [XW-1:0] i_x;
  logic [XW-1:0] i_y;
  logic          o_busy;
  logic          o_valid;
  logic [ZW-1:0] o_phi;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [ZW-1:0] exp_q[$];
  longint        tol_q[$];

  typedef struct {
    longint x;
    longint y;
    longint exp;
    longint tol;
    string  name;
  } vec_t;

  vec_t vt[6];

  atan2_clocked #(.pd(PD), .p(P), .ITER(ITER)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_x         (i_x),
    .i_y         (i_y),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_phi       (o_phi),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req, input longint tol);
    longint d;
    checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  function automatic longint ref_atan2(input longint x, input longint y);
    real r;
    r = $atan2(real'(y), real'(x)) * (2.0 ** P);
    return longint'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction

  // Drive one start at the next negedge, then wait (bounded) for o_valid and
  // score the result. poke_at > 0 pulses a bogus start that many cycles in.
  task automatic run_op(input longint x, input longint y, input longint exp, input longint tol,
                        input string name, input int poke_at,
                        output int lat, output int busy_n);
    logic [ZW-1:0] e;
    longint        t;
    logic          got;
    @(negedge clk);
    i_x = XW'(x);
    i_y = XW'(y);
    i_start = 1'b1;
    exp_q.push_back(exp[ZW-1:0]);
    tol_q.push_back(tol);
    lat = 0;
    busy_n = 0;
    got = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        i_start = 1'b0;
        i_x = XW'($urandom);
        i_y = XW'($urandom);
      end
      if (poke_at > 0 && c == poke_at) i_start = 1'b1;
      if (poke_at > 0 && c == poke_at + 1) i_start = 1'b0;
      if (o_busy) busy_n++;
      if (o_valid) begin
        lat = c;
        got = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    t = tol_q.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no o_valid, need one within 60 cycles", name);
    end else begin
      check(name, longint'($signed(o_phi)), longint'($signed(e)), t);
    end
  endtask

  // Count o_valid pulses over a window; none are expected.
  task automatic quiet_window(input int n, input string name);
    int cnt;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (o_valid) cnt++;
    end
    check(name, cnt, 0, 0);
  endtask

  initial begin
    int lat;
    int busy_n;
    longint b;
    longint xr;
    longint yr;
    real th;
    real mag;

    b = 64'sd16735272;
    vt[0] = '{ONE,  0,    0,         16, "x1_y0"};
    vt[1] = '{0,    ONE,  6588397,   16, "x0_y1"};
    vt[2] = '{ONE,  -ONE, -3294199,  16, "x1_ym1"};
    vt[3] = '{-ONE, 0,    13176795,  16, "xm1_y0"};
    vt[4] = '{0,    0,    0,         0,  "zero"};
    vt[5] = '{b,    b,    3294199,   16, "big_diag"};

    rst = 1'b1;
    i_start = 1'b0;
    i_x = '0;
    i_y = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0, 0);
    check("rst_valid", o_valid, 0, 0);
    check("rst_phi", longint'(o_phi), 0, 0);
    check("rst_state", longint'(dbg_state), longint'(ST_IDLE), 0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].x, vt[i].y, vt[i].exp, vt[i].tol, vt[i].name, 0, lat, busy_n);
      if (i == 0) begin
        check("latency", lat, ITER + 1, 0);
        check("busy_cycles", busy_n, ITER + 1, 0);
        repeat (3) @(negedge clk);
        check("phi_held", longint'($signed(o_phi)), vt[0].exp, 16);
        check("idle_busy", o_busy, 0, 0);
      end
    end

    // Just below -pi: y one LSB negative
    run_op(-ONE, -1, ref_atan2(-ONE, -1), 16, "xm1_ym1lsb", 0, lat, busy_n);
    check("xm1_ym1lsb_sign", o_phi[ZW-1], 1, 0);

    // Start pulsed mid-rotation with other operands: must be ignored
    run_op(ONE, ONE, 3294199, 16, "poke_mid", 10, lat, busy_n);
    // Start held on the o_valid cycle with bogus operands, then the real
    // start on the following IDLE cycle must be accepted
    i_x = XW'(-ONE);
    i_y = XW'(ONE / 2);
    i_start = 1'b1;
    run_op(0, -ONE, -6588397, 16, "after_valid", 0, lat, busy_n);
    check("after_valid_latency", lat, ITER + 1, 0);
    quiet_window(30, "no_extra_valid");

    // Reset at iteration ~10 aborts the request
    @(negedge clk);
    i_x = XW'(ONE);
    i_y = XW'(ONE);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", o_busy, 0, 0);
    check("abort_valid", o_valid, 0, 0);
    check("abort_phi", longint'(o_phi), 0, 0);
    quiet_window(40, "abort_no_valid");

    // Random angle sweep
    for (int i = 0; i < 1000; i++) begin
      th  = (real'($urandom_range(0, 1000000)) / 1000000.0 * 2.0 - 1.0) * 3.141592653589793;
      mag = 0.25 + real'($urandom_range(0, 3600)) / 1000.0;
      xr  = longint'($rtoi(mag * $cos(th) * (2.0 ** P)));
      yr  = longint'($rtoi(mag * $sin(th) * (2.0 ** P)));
      run_op(xr, yr, ref_atan2(xr, yr), SWEEP_TOL, "sweep", 0, lat, busy_n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
